// File: rtl/axi_read_arbiter_pkg.sv
// axi_read_arbiter_pkg: shared bus typedefs, AXI constants and arbiter FSM states
package axi_read_arbiter_pkg;
    typedef logic [31:0] axi_addr_t;
    typedef logic [31:0] axi_data_t;
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} arb_state_t;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [2:0] SIZE_1B = 3'd0;
    localparam logic [2:0] SIZE_2B = 3'd1;
    localparam logic [2:0] SIZE_4B = 3'd2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b >= n) ? a + b - n : a + b;
    endfunction
endpackage

// File: rtl/axi_read_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requester at or after ptr
module rr_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          any
);
    int w_j;
    always_comb begin
        grant = '0;
        index = '0;
        any   = |req;
        w_j   = 0;
        // Scan farthest-first so the requester closest to ptr wins last
        for (int i = N - 1; i >= 0; i--) begin
            w_j = wrap_add(int'(ptr), i, N);
            if (req[w_j]) begin
                grant      = '0;
                grant[w_j] = 1'b1;
                index      = IW'(w_j);
            end
        end
    end
endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin funnel of NUM_PORTS read requesters onto one AXI3
// read master, one outstanding burst at a time.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int ID_WIDTH  = 4,
    parameter int LEN_WIDTH = 4
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic [NUM_PORTS-1:0]                port_req_valid,
    input  logic [NUM_PORTS-1:0][31:0]          port_req_addr,
    input  logic [NUM_PORTS-1:0][LEN_WIDTH-1:0] port_req_len,
    input  logic [NUM_PORTS-1:0][2:0]           port_req_size,
    output logic [NUM_PORTS-1:0]                port_req_ready,
    output logic [31:0]                         port_rdata,
    output logic [NUM_PORTS-1:0]                port_rvalid,
    output logic                                port_rlast,
    output logic                                port_rerr,
    output logic [ID_WIDTH-1:0]                 arid,
    output logic [31:0]                         araddr,
    output logic [LEN_WIDTH-1:0]                arlen,
    output logic [2:0]                          arsize,
    output logic [1:0]                          arburst,
    output logic [1:0]                          arlock,
    output logic [3:0]                          arcache,
    output logic [2:0]                          arprot,
    output logic                                arvalid,
    input  logic                                arready,
    input  logic [ID_WIDTH-1:0]                 rid,
    input  logic [31:0]                         rdata,
    input  logic [1:0]                          rresp,
    input  logic                                rlast,
    input  logic                                rvalid,
    output logic                                rready,
    output logic                                id_mismatch
);
    localparam int PW = $clog2(NUM_PORTS);

    arb_state_t           r_state, w_next;
    logic [PW-1:0]        r_ptr, r_idx, w_idx;
    axi_addr_t            r_addr;
    logic [LEN_WIDTH-1:0] r_len;
    logic [2:0]           r_size;
    logic                 r_id_mismatch;
    logic [NUM_PORTS-1:0] w_grant, w_own;
    logic                 w_any;

    rr_arbiter #(.N(NUM_PORTS), .IW(PW)) u_rr (
        .req   (port_req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .index (w_idx),
        .any   (w_any)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_idx         <= '0;
            r_addr        <= '0;
            r_len         <= '0;
            r_size        <= '0;
            r_id_mismatch <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_any) begin
                r_idx  <= w_idx;
                r_ptr  <= (w_idx == PW'(NUM_PORTS - 1)) ? '0 : w_idx + 1'b1;
                r_addr <= port_req_addr[w_idx];
                r_len  <= port_req_len[w_idx];
                r_size <= port_req_size[w_idx];
            end
            if (r_state == ST_DATA && rvalid && rid != arid)
                r_id_mismatch <= 1'b1;
        end
    end

    // Handshake outputs decode straight from state so reset clears them at once
    always_comb begin
        w_next         = r_state;
        port_req_ready = '0;
        port_rvalid    = '0;
        arvalid        = 1'b0;
        rready         = 1'b0;
        case (r_state)
            ST_IDLE: if (w_any) begin
                w_next         = ST_ADDR;
                port_req_ready = w_grant;
            end
            ST_ADDR: begin
                arvalid = 1'b1;
                if (arready) w_next = ST_DATA;
            end
            ST_DATA: begin
                rready      = 1'b1;
                port_rvalid = rvalid ? w_own : '0;
                if (rvalid && rlast) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_own       = NUM_PORTS'(1) << r_idx;
    assign arid        = ID_WIDTH'(r_idx);
    assign araddr      = r_addr;
    assign arlen       = r_len;
    assign arsize      = r_size;
    assign arburst     = BURST_INCR;
    assign arlock      = 2'b00;
    assign arcache     = 4'b0000;
    assign arprot      = 3'b000;
    assign port_rdata  = rdata;
    assign port_rlast  = rlast;
    assign port_rerr   = rresp != RESP_OKAY;
    assign id_mismatch = r_id_mismatch;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: randomized traffic against a transaction-level arbiter model,
// plus a 5-port instance for pointer wrap.
module tb_axi_read_arbiter;
    localparam int N = 3;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    logic [N-1:0]       req_v = '0, req_ready, prv;
    logic [N-1:0][31:0] req_addr = '0;
    logic [N-1:0][3:0]  req_len = '0;
    logic [N-1:0][2:0]  req_size = '0;
    logic [31:0]        prdata, araddr, rdata = '0;
    logic               prlast, prerr, arvalid, rready, mism;
    logic [3:0]         arid, arlen, rid = '0;
    logic [2:0]         arsize, arprot;
    logic [1:0]         arburst, arlock, rresp = '0;
    logic [3:0]         arcache;
    logic               arready = 1'b0, rlast = 1'b0, rvalid = 1'b0;

    axi_read_arbiter #(.NUM_PORTS(N), .ID_WIDTH(4), .LEN_WIDTH(4)) dut (
        .aclk(aclk), .areset(areset),
        .port_req_valid(req_v), .port_req_addr(req_addr), .port_req_len(req_len),
        .port_req_size(req_size), .port_req_ready(req_ready), .port_rdata(prdata),
        .port_rvalid(prv), .port_rlast(prlast), .port_rerr(prerr),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready), .id_mismatch(mism)
    );

    logic [4:0]         b_req_v = '0, b_ready, b_prv;
    logic [4:0][31:0]   b_addr = '0;
    logic [4:0][3:0]    b_len = '0;
    logic [4:0][2:0]    b_size = '0;
    logic [31:0]        b_prdata, b_araddr;
    logic               b_prlast, b_prerr, b_arvalid, b_rready, b_mism;
    logic [3:0]         b_arid, b_arlen;
    logic [2:0]         b_arsize, b_arprot;
    logic [1:0]         b_arburst, b_arlock;
    logic [3:0]         b_arcache;

    axi_read_arbiter #(.NUM_PORTS(5), .ID_WIDTH(4), .LEN_WIDTH(4)) dut5 (
        .aclk(aclk), .areset(areset),
        .port_req_valid(b_req_v), .port_req_addr(b_addr), .port_req_len(b_len),
        .port_req_size(b_size), .port_req_ready(b_ready), .port_rdata(b_prdata),
        .port_rvalid(b_prv), .port_rlast(b_prlast), .port_rerr(b_prerr),
        .arid(b_arid), .araddr(b_araddr), .arlen(b_arlen), .arsize(b_arsize),
        .arburst(b_arburst), .arlock(b_arlock), .arcache(b_arcache), .arprot(b_arprot),
        .arvalid(b_arvalid), .arready(1'b1), .rid(4'd4), .rdata(32'h0), .rresp(2'b00),
        .rlast(1'b1), .rvalid(1'b1), .rready(b_rready), .id_mismatch(b_mism)
    );

    int checks = 0, errors = 0;
    int ph = 0, ptr = 0, g = 0, mlen = 0, beat = 0;
    logic [31:0] maddr = '0;
    logic [2:0]  msize = '0;
    bit          mis = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int pct);
        for (int p = 0; p < N; p++) begin
            req_v[p]    = ($urandom % 100) < pct;
            req_addr[p] = $urandom;
            req_len[p]  = 4'($urandom);
            req_size[p] = 3'($urandom);
        end
        arready = 1'($urandom);
        rvalid  = ($urandom % 100) < 60;
        rdata   = $urandom;
        rresp   = 2'($urandom);
        rlast   = (ph == 2) ? (beat == mlen) : 1'($urandom);
        rid     = ($urandom % 8 == 0) ? 4'($urandom) : 4'(g);
    endtask

    task automatic check_and_update();
        int gg;
        logic [N-1:0] exp_ready;
        gg = -1;
        exp_ready = '0;
        if (ph == 0)
            for (int k = N - 1; k >= 0; k--)
                if (req_v[(ptr + k) % N]) gg = (ptr + k) % N;
        if (gg >= 0) exp_ready[gg] = 1'b1;
        chk("ready", req_ready, exp_ready);
        chk("arvalid", arvalid, ph == 1);
        chk("rready", rready, ph == 2);
        chk("rvalid", prv, (ph == 2 && rvalid) ? (1 << g) : 0);
        chk("id_mismatch", mism, mis);
        if (ph == 1) begin
            chk("arid", arid, g);
            chk("araddr", araddr, maddr);
            chk("arlen", arlen, mlen);
            chk("arsize", arsize, msize);
            chk("arburst", arburst, 1);
        end
        if (ph == 2 && rvalid) begin
            chk("rdata", prdata, rdata);
            chk("rlast", prlast, rlast);
            chk("rerr", prerr, rresp != 0);
        end
        case (ph)
            0: if (gg >= 0) begin
                g = gg; maddr = req_addr[g]; mlen = int'(req_len[g]); msize = req_size[g];
                ptr = (g + 1) % N; ph = 1;
            end
            1: if (arready) begin ph = 2; beat = 0; end
            2: if (rvalid) begin
                if (int'(rid) != g) mis = 1;
                if (rlast) ph = 0; else beat++;
            end
            default: ph = 0;
        endcase
    endtask

    task automatic step(input int pct);
        @(posedge aclk); #1;
        drive(pct);
        @(negedge aclk);
        check_and_update();
    endtask

    initial begin
        int waited;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_mismatch", mism, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        b_req_v = 5'b10000;
        @(negedge aclk);
        chk("p5_grant4", b_ready, 5'b10000);
        @(posedge aclk); #1;
        b_req_v = 5'b11111;
        @(posedge aclk);
        @(negedge aclk);
        chk("p5_beat", b_prv, 5'b10000);
        @(posedge aclk);
        @(negedge aclk);
        chk("p5_wrap", b_ready, 5'b00001);
        @(posedge aclk); #1;
        b_req_v = '0;
        repeat (300) step(40);
        repeat (200) step(100);
        repeat (100) step(10);
        waited = 0;
        while (!(ph == 2 && beat >= 1) && waited < 500) begin
            step(100);
            waited++;
        end
        chk("reach_data", waited < 500, 1);
        rvalid = 1'b1;
        areset = 1'b1;
        #1;
        chk("abort_rready", rready, 0);
        chk("abort_arvalid", arvalid, 0);
        chk("abort_rvalid", prv, 0);
        chk("abort_mismatch", mism, 0);
        ph = 0; ptr = 0; mis = 0;
        @(posedge aclk); #1;
        areset = 1'b0;
        rvalid = 1'b0;
        @(negedge aclk);
        chk("post_rst_idle", rready, 0);
        repeat (50) step(100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of upstream read requesters (2..8).
REQ-002 SHALL have parameter ID_WIDTH, default 4, AXI ID width; the granted port index is zero-extended onto arid.
REQ-003 SHALL have parameter LEN_WIDTH, default 4, width of the burst-length fields (AXI3 beats-1 encoding).
REQ-004 SHALL have one clock, aclk; reset is asynchronous and active-high, named areset.
REQ-005 aclk  in  1  clock, all state on rising edge.
REQ-006 areset  in  1  asynchronous active-high reset.
REQ-007 port_req_valid  in  NUM_PORTS  per-port read request valid.
REQ-008 port_req_addr  in  NUM_PORTS x 32  per-port start address.
REQ-009 port_req_len  in  NUM_PORTS x LEN_WIDTH  per-port beats-1.
REQ-010 port_req_size  in  NUM_PORTS x 3  per-port AXI size.
REQ-011 port_req_ready  out  NUM_PORTS  request accepted this cycle (one-hot or zero).
REQ-012 port_rdata  out  32  read data, shared by all ports.
REQ-013 port_rvalid  out  NUM_PORTS  one-hot beat valid for the owning port.
REQ-014 port_rlast  out  1  final beat marker.
REQ-015 port_rerr  out  1  rresp of the current beat is non-zero.
REQ-016 arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid out; arready in -- AXI3 AR channel.
REQ-017 rid/rdata/rresp/rlast/rvalid in; rready out -- AXI3 R channel.

Function
REQ-018 SHALL use FSM IDLE -> ADDR -> DATA -> IDLE; one outstanding burst at a time.
REQ-019 In IDLE with any port_req_valid, SHALL grant round-robin starting at rr_ptr; assert port_req_ready[g] that cycle, latch addr/len/size, go to ADDR.
REQ-020 In IDLE with no request, SHALL stay in IDLE with all port_req_ready low.
REQ-021 After a grant, rr_ptr SHALL become (g+1) mod NUM_PORTS; rr_ptr SHALL wrap correctly when NUM_PORTS is not a power of two.
REQ-022 In ADDR, arvalid SHALL be 1 and AR fields constant until arready; on arvalid&arready, go to DATA next cycle.
REQ-023 Constant AR fields: arburst=2'b01 (INCR), arlock=0, arcache=0, arprot=0.
REQ-024 In DATA, rready SHALL be 1; each rvalid beat is forwarded combinationally to port_rvalid[g], with port_rdata=rdata, port_rlast=rlast, port_rerr=(rresp!=0).
REQ-025 On rvalid&rlast in DATA, SHALL return to IDLE; a new grant is allowed on the next cycle (1 idle cycle between bursts).
REQ-026 Requests arriving during ADDR/DATA SHALL wait; port_req_ready SHALL be 0 outside IDLE.
REQ-027 A beat with rid != granted ID SHALL still be consumed and forwarded, and a sticky internal id_mismatch flag SHALL be set (debug-visible, cleared only by reset).
REQ-028 Outside DATA, rready SHALL be 0 and port_rvalid SHALL be 0.
REQ-029 Ports dropping port_req_valid before grant SHALL simply not be granted.

Reset
REQ-030 On areset: state=IDLE, rr_ptr=0, arvalid=0, rready=0, port_req_ready=0, port_rvalid=0, latched AR fields=0, id_mismatch=0.
REQ-031 areset asserted mid-burst SHALL abort immediately; no further beat is forwarded and arvalid drops asynchronously.

Structure
REQ-032 The state enum, AXI burst/size constants and rresp codes SHALL reside in the shared bus package alongside the existing bus typedefs.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot grant and index).

Verification
REQ-034 NUM_PORTS=3, only port1 requests addr 0x1000 len 3 -> arid=1, arlen=3, four beats on port_rvalid[1], rlast on the 4th, back to IDLE.
REQ-035 All three ports request continuously -> grants in order 0,1,2,0; one idle cycle between bursts.
REQ-036 arready held low 5 cycles -> arvalid and araddr stable all 5 cycles, no rready.
REQ-037 Beat with rresp=2'b10 -> port_rerr=1 for that beat only.
REQ-038 areset during beat 2 of 4 -> next cycle IDLE, rready=0, no further port_rvalid; a new request is granted to port0.
REQ-039 NUM_PORTS=5, port4 granted -> rr_ptr wraps to 0.
